// File: rtl/ntsc_pkg.sv
// Shared definitions for the NTSC pixel pipeline.
//   PIXEL_W / COORD_W : widths of pixel codes and screen coordinates
//   pixel_code_t      : 3-bit colour codes understood by the Ntsc timing stage
//   fetch_state_t     : line fetcher FSM states
//   pix_code()        : maps a 2-bit source pixel onto the visible grey ramp
package ntsc_pkg;

  localparam int PIXEL_W = 3;
  localparam int COORD_W = 10;

  typedef enum logic [PIXEL_W-1:0] {
    PIX_BLANK        = 3'd0,
    PIX_DARK_GREY    = 3'd1,
    PIX_GREY         = 3'd2,
    PIX_LIGHT_GREY   = 3'd3,
    PIX_WHITE        = 3'd4,
    PIX_BRIGHT_WHITE = 3'd5
  } pixel_code_t;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT,
    DRAIN,
    DONE
  } fetch_state_t;

  // Source value 0..3 becomes dark grey..white; blank is never produced here.
  function automatic logic [PIXEL_W-1:0] pix_code(input logic [1:0] v);
    return PIX_DARK_GREY + PIXEL_W'(v);
  endfunction

endpackage

// File: rtl/line_fetcher_if.sv
// Framebuffer read port between the line fetcher (master) and memory (slave).
//   mem_req    : read request, held with mem_addr until accepted
//   mem_addr   : pixel address in the framebuffer
//   mem_ack    : request accepted when mem_req && mem_ack
//   mem_rvalid : read data valid, in order, >= 1 cycle after acceptance
//   mem_rdata  : 2-bit source pixel
interface line_fetcher_if #(
  parameter int ADDR_W = 15
) ();

  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_ack;
  logic              mem_rvalid;
  logic [1:0]        mem_rdata;

  modport master (
    output mem_req,
    output mem_addr,
    input  mem_ack,
    input  mem_rvalid,
    input  mem_rdata
  );

  modport slave (
    input  mem_req,
    input  mem_addr,
    output mem_ack,
    output mem_rvalid,
    output mem_rdata
  );

endinterface

// File: rtl/line_buffer_ram.sv
// Ping-pong line storage: simple dual-port RAM, synchronous write (fetch side)
// and synchronous read (display side). Contents are never reset; validity is
// tracked by the owner.
//   clk   : clock
//   we    : write enable
//   waddr : write address {bank, col}
//   wdata : write data
//   raddr : read address {bank, col}
//   rdata : registered read data (one cycle after raddr)
module line_buffer_ram #(
  parameter int AW     = 8,
  parameter int DATA_W = 2
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [0:(2**AW)-1];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/line_fetcher.sv
// Line fetcher: fills the back bank of a ping-pong line buffer with the next
// source row over the framebuffer handshake, while the front bank feeds the
// Ntsc timing stage with 3-bit pixel codes.
//   clk, reset       : pixel clock, synchronous active-high reset
//   line_start       : 1-cycle pulse at end of each line; swaps banks
//   fetch_y          : row to fetch, sampled on line_start
//   pixel_x          : current output column from Ntsc
//   pixel_is_visible : Ntsc visible-area flag
//   pixel_data       : pixel code, one cycle after pixel_x
//   overrun          : 1-cycle pulse when a line starts before the fetch ended
//   mem              : framebuffer read port (master)
module line_fetcher
  import ntsc_pkg::*;
#(
  parameter int SRC_W    = 128,
  parameter int SRC_H    = 200,
  parameter int ADDR_W   = 15,
  parameter int X_OFFSET = 128,
  parameter int X_SHIFT  = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               line_start,
  input  logic [COORD_W-1:0] fetch_y,
  input  logic [COORD_W-1:0] pixel_x,
  input  logic               pixel_is_visible,
  output logic [PIXEL_W-1:0] pixel_data,
  output logic               overrun,
  line_fetcher_if.master     mem
);

  localparam int CW = $clog2(SRC_W);
  localparam logic [COORD_W-1:0] SRC_H_C = COORD_W'(SRC_H);
  localparam logic [COORD_W-1:0] SRC_W_C = COORD_W'(SRC_W);
  localparam logic [COORD_W-1:0] X_OFF_C = COORD_W'(X_OFFSET);

  // SRC_W is a power of two, so row*SRC_W + col is a plain concatenation.
  function automatic logic [ADDR_W-1:0] addr_of(input logic [COORD_W-1:0] y,
                                                input logic [CW-1:0]      c);
    return ADDR_W'({y, c});
  endfunction

  fetch_state_t       state;
  logic [CW-1:0]      col;
  logic [CW-1:0]      col_nxt;
  logic               front;
  logic [1:0]         bank_valid;
  logic [COORD_W-1:0] fy;
  logic               row_ok;
  logic               row_ok_in;
  logic               wr_en;
  logic               last_beat;
  logic               must_drain;

  assign row_ok_in = (fetch_y < SRC_H_C);
  assign wr_en     = (state == WAIT) && mem.mem_rvalid;
  assign last_beat = wr_en && (&col);
  assign col_nxt   = col + CW'(1);

  // A read is still in flight after this edge if we are waiting without data,
  // or the request is being accepted right now.
  assign must_drain = (((state == WAIT) || (state == DRAIN)) && !mem.mem_rvalid) ||
                      ((state == REQ) && mem.mem_ack);

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      col          <= '0;
      front        <= 1'b0;
      bank_valid   <= 2'b00;
      fy           <= '0;
      row_ok       <= 1'b0;
      mem.mem_req  <= 1'b0;
      mem.mem_addr <= '0;
      overrun      <= 1'b0;
    end else begin
      overrun <= 1'b0;
      if (line_start) begin
        front  <= ~front;
        fy     <= fetch_y;
        row_ok <= row_ok_in;
        col    <= '0;
        // Old front becomes the new back and is cleared. Old back becomes the
        // new front: valid only if its fetch finished (possibly on this edge).
        bank_valid[front]  <= 1'b0;
        bank_valid[~front] <= bank_valid[~front] | last_beat;
        overrun <= (state == REQ) || (state == DRAIN) ||
                   ((state == WAIT) && !last_beat);
        if (must_drain) begin
          state       <= DRAIN;
          mem.mem_req <= 1'b0;
        end else if (row_ok_in) begin
          state        <= REQ;
          mem.mem_req  <= 1'b1;
          mem.mem_addr <= addr_of(fetch_y, '0);
        end else begin
          state       <= IDLE;
          mem.mem_req <= 1'b0;
        end
      end else begin
        case (state)
          IDLE: ;
          REQ: begin
            if (mem.mem_ack) begin
              state       <= WAIT;
              mem.mem_req <= 1'b0;
            end
          end
          WAIT: begin
            if (mem.mem_rvalid) begin
              if (&col) begin
                state              <= DONE;
                bank_valid[~front] <= 1'b1;
              end else begin
                state        <= REQ;
                col          <= col_nxt;
                mem.mem_req  <= 1'b1;
                mem.mem_addr <= addr_of(fy, col_nxt);
              end
            end
          end
          DRAIN: begin
            // The one stale read returns here and is dropped.
            if (mem.mem_rvalid) begin
              if (row_ok) begin
                state        <= REQ;
                mem.mem_req  <= 1'b1;
                mem.mem_addr <= addr_of(fy, '0);
              end else begin
                state <= IDLE;
              end
            end
          end
          DONE:    state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

  // ---- stage p0: pixel_x -> buffer read address and window gate ----
  logic [COORD_W-1:0] dx_p0;
  logic [COORD_W-1:0] sx_p0;
  logic               vld_p0;
  logic [CW:0]        rd_addr_p0;

  assign dx_p0      = pixel_x - X_OFF_C;
  assign sx_p0      = dx_p0 >> X_SHIFT;
  assign vld_p0     = pixel_is_visible && (pixel_x >= X_OFF_C) &&
                      (sx_p0 < SRC_W_C) && bank_valid[front];
  assign rd_addr_p0 = {front, sx_p0[CW-1:0]};

  // ---- stage p1: registered RAM data and gate -> pixel code ----
  logic       vld_p1;
  logic [1:0] rd_p1;

  line_buffer_ram #(
    .AW     (CW + 1),
    .DATA_W (2)
  ) u_ram (
    .clk   (clk),
    .we    (wr_en),
    .waddr ({~front, col}),
    .wdata (mem.mem_rdata),
    .raddr (rd_addr_p0),
    .rdata (rd_p1)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      vld_p1 <= 1'b0;
    end else begin
      vld_p1 <= vld_p0;
    end
  end

  assign pixel_data = vld_p1 ? pix_code(rd_p1) : PIXEL_W'(PIX_BLANK);

endmodule

// File: tb/tb_line_fetcher.sv
// Directed bench for line_fetcher with a behavioural framebuffer whose word
// at address a holds a % 4 (so every row reads back col % 4).
module tb_line_fetcher;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       line_start = 1'b0;
  logic [9:0] fetch_y = '0;
  logic [9:0] pixel_x = '0;
  logic       pixel_is_visible = 1'b0;
  logic [2:0] pixel_data;
  logic       overrun;

  always #5 clk = ~clk;

  line_fetcher_if #(.ADDR_W(15)) mif ();

  line_fetcher #(
    .SRC_W(128), .SRC_H(200), .ADDR_W(15), .X_OFFSET(128), .X_SHIFT(1)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .line_start       (line_start),
    .fetch_y          (fetch_y),
    .pixel_x          (pixel_x),
    .pixel_is_visible (pixel_is_visible),
    .pixel_data       (pixel_data),
    .overrun          (overrun),
    .mem              (mif)
  );

  // ---------------- memory model ----------------
  logic       m_ack = 1'b0;
  logic       m_rvalid = 1'b0;
  logic [1:0] m_rdata = 2'b00;
  assign mif.mem_ack    = m_ack;
  assign mif.mem_rvalid = m_rvalid;
  assign mif.mem_rdata  = m_rdata;

  int          lat = 1;        // written by stimulus only
  int          stall_req = 0;  // written by stimulus only
  int          stall_used = 0;
  int          acc_log[$];
  int          rv_cnt = 0;
  int          ovr_cnt = 0;
  int          ooo_err = 0;
  bit          pend = 1'b0;
  int          cnt = 0;
  logic [14:0] paddr = '0;
  logic [14:0] ack_addr = '0;

  always @(negedge clk) begin
    if (m_ack) begin
      if (pend) ooo_err++;
      acc_log.push_back(int'(ack_addr));
      pend  = 1'b1;
      paddr = ack_addr;
      cnt   = lat;
    end
    m_rvalid = 1'b0;
    if (pend) begin
      cnt--;
      if (cnt <= 0) begin
        m_rvalid = 1'b1;
        m_rdata  = paddr[1:0];
        pend     = 1'b0;
        rv_cnt++;
      end
    end
    if (mif.mem_req && stall_used < stall_req) begin
      stall_used++;
      m_ack = 1'b0;
    end else begin
      m_ack = mif.mem_req;
    end
    ack_addr = mif.mem_addr;
    if (overrun) ovr_cnt++;
  end

  // ---------------- checking ----------------
  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_line(input int y);
    fetch_y    = 10'(y);
    line_start = 1'b1;
    @(negedge clk);
    line_start = 1'b0;
  endtask

  task automatic wait_rv(input int r0, input int n, input int budget, input string tag);
    int c;
    c = 0;
    while ((rv_cnt - r0) < n && c < budget) begin
      @(negedge clk);
      c++;
    end
    chk(tag, rv_cnt - r0, n);
  endtask

  task automatic check_row(input string pfx, input int m, input int base);
    int errs;
    errs = 0;
    chk({pfx, "_nreq"}, acc_log.size() - m, 128);
    chk({pfx, "_first"}, (acc_log.size() > m) ? acc_log[m] : -1, base);
    chk({pfx, "_last"}, (acc_log.size() > m) ? acc_log[acc_log.size()-1] : -1, base + 127);
    for (int i = 0; i < 128; i++)
      if (acc_log.size() > m + i && acc_log[m+i] != base + i) errs++;
    chk({pfx, "_seq"}, errs, 0);
  endtask

  // Pixel codes: x in 128..383 -> ((x-128)>>1)%4 + 1, else 0.
  task automatic sweep(input string tag, input bit blank);
    int e;
    for (int x = 126; x <= 385; x++) begin
      pixel_x = 10'(x);
      pixel_is_visible = 1'b1;
      @(negedge clk);
      e = (blank || x < 128 || x > 383) ? 0 : (((x - 128) >> 1) % 4) + 1;
      chk($sformatf("%s_x%0d", tag, x), pixel_data, e);
    end
    pixel_is_visible = 1'b0;
  endtask

  initial begin
    int m, r, o, bad;

    tick(3);
    chk("rst_pix", pixel_data, 0);
    chk("rst_req", mif.mem_req, 0);
    chk("rst_addr", mif.mem_addr, 0);
    chk("rst_ovr", overrun, 0);
    reset = 1'b0;
    tick(2);

    // Row 0 with 1-cycle memory.
    lat = 1;
    m = acc_log.size(); r = rv_cnt; o = ovr_cnt;
    pulse_line(0);
    wait_rv(r, 128, 400, "t1_done_le400");
    check_row("t1", m, 0);
    chk("t1_ovr", ovr_cnt - o, 0);
    tick(3);

    // Display row 0 while fetching row 5.
    m = acc_log.size(); r = rv_cnt;
    pulse_line(5);
    sweep("row0", 1'b0);
    wait_rv(r, 128, 400, "t2_done");
    check_row("t2", m, 640);
    tick(3);

    // Blank source row: no requests, that line outputs nothing.
    m = acc_log.size();
    pulse_line(200);
    chk("blank_req", mif.mem_req, 0);
    pixel_x = 10'd200; pixel_is_visible = 1'b0;
    tick(1);
    chk("invisible", pixel_data, 0);
    sweep("row5", 1'b0);
    pulse_line(200);
    sweep("blankrow", 1'b1);
    chk("blank_nreq", acc_log.size() - m, 0);
    chk("blank_ovr", ovr_cnt - o, 0);

    // Slow memory: fetch cannot keep up with the line rate.
    reset = 1'b1; tick(2); reset = 1'b0; tick(40);
    lat = 30; o = ovr_cnt;
    pulse_line(0);
    tick(3174);
    m = acc_log.size();
    pulse_line(1);
    tick(1);
    chk("ovr_first", ovr_cnt - o, 1);
    sweep("ovrfront", 1'b1);
    chk("drain_next_addr", (acc_log.size() > m) ? acc_log[m] : -1, 128);
    tick(2900);
    pulse_line(2);
    tick(2);
    chk("ovr_second", ovr_cnt - o, 2);
    chk("one_outstanding", ooo_err, 0);

    // Acknowledge withheld for 50 cycles.
    reset = 1'b1; tick(2); reset = 1'b0; tick(40);
    lat = 1;
    stall_req = stall_used + 50;
    m = acc_log.size(); r = rv_cnt;
    pulse_line(3);
    bad = 0;
    for (int i = 0; i < 49; i++) begin
      if (mif.mem_req !== 1'b1 || mif.mem_addr !== 15'd384) bad++;
      tick(1);
    end
    chk("stall_stable", bad, 0);
    chk("stall_addr", mif.mem_addr, 384);
    wait_rv(r, 128, 500, "t5_done");
    check_row("t5", m, 384);
    tick(3);

    // Reset in WAIT, then a stray rvalid from the abandoned read.
    lat = 30;
    pulse_line(1);
    pixel_x = 10'd130; pixel_is_visible = 1'b1;
    tick(5);
    chk("pre_rst_pix", pixel_data, 2);
    r = rv_cnt;
    reset = 1'b1;
    tick(1);
    chk("mid_rst_req", mif.mem_req, 0);
    chk("mid_rst_pix", pixel_data, 0);
    reset = 1'b0;
    m = acc_log.size();
    wait_rv(r, 1, 60, "stray_rv_seen");
    tick(5);
    chk("stray_req", mif.mem_req, 0);
    chk("stray_nreq", acc_log.size() - m, 0);
    chk("stray_pix", pixel_data, 0);
    chk("final_outstanding", ooo_err, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
